aes_out_monitor: RTL and testbench
==================================

# aes_out_monitor

Response-side counterpart to the AES-128 stimulus generator. It consumes the ciphertext stream from the pipelined `aes_128` core. It waits out the core's fixed pipeline latency, then folds a programmed number of consecutive ciphertext words into a 128-bit MISR signature. When all words are folded, it reports done and pass/fail against an expected signature, so long randomized encryption runs self-check without per-vector golden data.

## Interface

Parameters:
- `DATA_WIDTH`, 128: ciphertext width. Must be 128; the MISR polynomial is fixed for 128.
- `LATENCY`, 21: enabled cycles from `start` to the first valid ciphertext word.
- `CNT_WIDTH`, 32: width of the word counter and of `num_tests`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: core clock, the same clock as `aes_128`.
- `rst_n`, input, 1: asynchronous active-low reset.
- `enable`, input, 1: pipeline-advance qualifier. Mirrors the core clock enable. The block does nothing on cycles where it is low.
- `start`, input, 1: single-cycle pulse that begins a run. Ignored unless in IDLE or DONE.
- `num_tests`, input, CNT_WIDTH: number of words to fold. Sampled on `start`. A value of 0 is treated as 1.
- `out_data`, input, 128: ciphertext from `aes_128.out`.
- `expected_sig`, input, 128: golden signature. Sampled in the DONE-entry cycle.
- `busy`, output, 1: high in WAIT and CAPTURE.
- `done`, output, 1: high in DONE.
- `pass`, output, 1: valid while `done` is high. High when `sig` equals `expected_sig`.
- `sig`, output, 128: current MISR value.
- `word_count`, output, CNT_WIDTH: number of words folded so far in this run.

## Operation

- **States:** IDLE, WAIT, CAPTURE, DONE. Reset places the block in IDLE.
- **IDLE or DONE, on `start`:**
  - `sig` clears to 0 and `word_count` clears to 0.
  - The latency counter loads `LATENCY-1`.
  - The target count `max(num_tests,1)` is latched.
  - The state moves to WAIT.
- **WAIT:** On each cycle with `enable` high, the counter decrements. When the counter is 0 and `enable` is high, the state moves to CAPTURE. There is no capture on that cycle.
- **CAPTURE:** On each cycle with `enable` high:
  - `sig <= ({sig[126:0],1'b0} ^ (sig[127] ? MISR_POLY : 0)) ^ out_data`, where `MISR_POLY = 128'h87` (GF(2^128) multiply by x).
  - `word_count` increments.
  - When the increment reaches the target, the state moves to DONE.
- **DONE:**
  - `pass` is registered on entry as `(sig_final == expected_sig)`.
  - `sig`, `word_count`, `done` and `pass` hold until the next `start`.
- **`enable` low in any state:** full stall. No state, counter or signature change.
- **`start` during WAIT or CAPTURE:** ignored. The run continues unchanged.
- **`start` coincident with the final capture:** ignored. DONE is entered normally, and a later `start` is required.
- **`rst_n` low mid-run:** immediately returns to IDLE and all outputs go to their reset values. A partial signature is never reported.
- **`word_count`:** saturates only by reaching the target. The target is at most 2^CNT_WIDTH-1.

## Timing

- **Reset values:** `busy`=0, `done`=0, `pass`=0, `sig`=0, `word_count`=0.
- **Run timeline:**
  - `start` is sampled at edge E0, and `busy` is high after E0.
  - With `enable` continuously high, the first fold samples `out_data` at edge E0+LATENCY+1.
  - The last fold is at E0+LATENCY+N.
  - `done` and `pass` are high after edge E0+LATENCY+N+1.
  - `busy` falls in the same cycle that `done` rises.
- **Stalls:** each low-`enable` cycle adds exactly one cycle to all of the points above.
- **`pass`:** one register stage after the final `sig` update. It is never high while `done` is low.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration

- **`AES_MON_SNAPSHOT_EN`:**
  - When defined, adds output `last_word[127:0]` (reset 0), which is the most recently folded `out_data`.
  - It also adds output `first_mismatch`, 1 bit. This is `pass` inverted, gated by `done`, and available for direct connection to an error LED or counter.
- **Without the macro:** neither port nor its registers exist. Signature behaviour is identical.

## Structure

- **Package `aes_mon_pkg`:** holds `MISR_POLY` (128'h87), the state enum `aes_mon_state_t` {IDLE, WAIT, CAPTURE, DONE}, and the default `LATENCY` constant (21).
- **Sub-module `aes_misr_128`:** the 128-bit MISR step. Its inputs are clk, rst_n, clear, fold, data, and its output is sig. The top-level FSM drives `clear` on `start` and `fold` on enabled CAPTURE cycles.

## Test plan

- **Single word:** `LATENCY`=2, `num_tests`=1, `out_data`=128'h1 constant, `enable` high. Expect `sig`=128'h1, `done` high at E0+4, and `pass`=1 with `expected_sig`=128'h1.
- **Two words:** `num_tests`=2, `out_data`=128'h1. Expect `sig`=128'h3 and `word_count`=2. With `expected_sig`=128'h2, expect `pass`=0.
- **Polynomial feedback:** two folds. The first uses `out_data`=128'h8000…0000 and the second uses 0. Expect `sig`=128'h87.
- **Stall:** `enable` low for 3 cycles mid-CAPTURE. Expect `done` 3 cycles later than the unstalled run and an identical `sig`.
- **Ignored `start` and reset mid-run:** a `start` pulse during WAIT leaves timing unchanged. `rst_n` low during CAPTURE gives all outputs 0, and a fresh `start` then completes correctly.
- **System run:** drive `aes_128` with LFSR-generated plaintext and key and set `num_tests`=64. Expect `pass`=1 against the signature from the C reference model. Also expect `done` at E0+21+64+1.

Source files
------------

// File: rtl/aes_mon_pkg.sv
// aes_out_monitor shared types and constants.
// MISR polynomial, FSM state enum, default core latency.
package aes_mon_pkg;

  localparam logic [127:0] MISR_POLY = 128'h87;
  localparam int AES_MON_LATENCY = 21;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    DONE
  } aes_mon_state_t;

endpackage

// File: rtl/aes_misr_128.sv
// 128-bit MISR step: sig <- (sig * x mod poly) ^ data.
// clear wins over fold.
module aes_misr_128
  import aes_mon_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         fold,
  input  logic [127:0] data,
  output logic [127:0] sig
);

  logic [127:0] sig_q;
  logic [127:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (fold) begin
      sig_d = {sig_q[126:0], 1'b0}
            ^ (sig_q[127] ? MISR_POLY : '0)
            ^ data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/aes_out_monitor.sv
// AES-128 response monitor: latency wait, then MISR fold of N words.
// Optional AES_MON_SNAPSHOT_EN adds last_word and first_mismatch ports.
module aes_out_monitor
  import aes_mon_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int LATENCY    = AES_MON_LATENCY,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_tests,
  input  logic [DATA_WIDTH-1:0] out_data,
  input  logic [DATA_WIDTH-1:0] expected_sig,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [DATA_WIDTH-1:0] sig,
`ifdef AES_MON_SNAPSHOT_EN
  output logic [DATA_WIDTH-1:0] last_word,
  output logic                  first_mismatch,
`endif
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int LAT_W =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD =
    LAT_W'(LATENCY - 1);

  aes_mon_state_t state_q, state_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [CNT_WIDTH-1:0] tgt_q, tgt_d;
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 clear;
  logic                 fold;
  logic                 accept;
  logic [127:0]         sig_w;

  // DONE with done_q low is the one-cycle report stage;
  // a start there would discard the result, so only
  // a fully reported DONE may restart.
  assign accept = enable && start &&
    ((state_q == IDLE) ||
     ((state_q == DONE) && done_q));

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    tgt_d   = tgt_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    clear   = 1'b0;
    fold    = 1'b0;
    if (accept) begin
      clear   = 1'b1;
      state_d = WAIT;
      lat_d   = LAT_LOAD;
      wcnt_d  = '0;
      tgt_d   = (num_tests == '0) ?
                CNT_WIDTH'(1) : num_tests;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else if (enable) begin
      unique case (state_q)
        IDLE: ;
        WAIT: begin
          if (lat_q == '0) begin
            state_d = CAPTURE;
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end
        CAPTURE: begin
          fold   = 1'b1;
          wcnt_d = wcnt_q + CNT_WIDTH'(1);
          if (wcnt_d == tgt_q) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (!done_q) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            pass_d = (sig_w == expected_sig);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      tgt_q   <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      tgt_q   <= tgt_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  aes_misr_128 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .fold  (fold),
    .data  (out_data),
    .sig   (sig_w)
  );

`ifdef AES_MON_SNAPSHOT_EN
  logic [DATA_WIDTH-1:0] last_q;
  logic                  fmis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      fmis_q <= 1'b0;
    end else begin
      if (fold) begin
        last_q <= out_data;
      end
      if (accept) begin
        fmis_q <= 1'b0;
      end else if (!done_q && done_d) begin
        fmis_q <= !pass_d;
      end
    end
  end

  assign last_word      = last_q;
  assign first_mismatch = fmis_q;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign sig        = sig_w;
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_aes_out_monitor.sv
// Directed self-checking bench for aes_out_monitor.
// Uses LATENCY=2 so done lands at E0+2+N+1.
module tb_aes_out_monitor;

  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         start;
  logic [31:0]  num_tests;
  logic [127:0] out_data;
  logic [127:0] expected_sig;
  logic         busy;
  logic         done;
  logic         pass;
  logic [127:0] sig;
  logic [31:0]  word_count;
`ifdef AES_MON_SNAPSHOT_EN
  logic [127:0] last_word;
  logic         first_mismatch;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int dk;

  always #5 clk = ~clk;

  aes_out_monitor #(
    .DATA_WIDTH (128),
    .LATENCY    (L),
    .CNT_WIDTH  (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .start        (start),
    .num_tests    (num_tests),
    .out_data     (out_data),
    .expected_sig (expected_sig),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .sig          (sig),
`ifdef AES_MON_SNAPSHOT_EN
    .last_word      (last_word),
    .first_mismatch (first_mismatch),
`endif
    .word_count   (word_count)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // d0 is sampled by the first fold, d1 by the rest.
  task automatic do_run(input logic [31:0]  n,
                        input logic [127:0] d0,
                        input logic [127:0] d1,
                        input logic [127:0] es,
                        input int           stall_at,
                        input int           start_at,
                        output int          done_k);
    int k;
    num_tests    = n;
    out_data     = d0;
    expected_sig = es;
    enable       = 1'b1;
    start        = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    k = 0;
    while (k < 300 && !done) begin
      if (k == L + 1) out_data = d1;
      enable = !(stall_at >= 0 && k >= stall_at &&
                 k < stall_at + 3);
      start  = (k == start_at);
      tick();
      k++;
    end
    start  = 1'b0;
    enable = 1'b1;
    chk("done_seen", done, 1);
    done_k = done ? k : -1;
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    start        = 1'b0;
    num_tests    = '0;
    out_data     = '0;
    expected_sig = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig", sig, 0);
    chk("rst_wc", word_count, 0);
    rst_n = 1'b1;
    tick();

    do_run(1, 128'h1, 128'h1, 128'h1, -1, -1, dk);
    chk("one_done_k", dk, L + 1 + 1);
    chk("one_sig", sig, 128'h1);
    chk("one_pass", pass, 1);
    chk("one_busy", busy, 0);
    chk("one_wc", word_count, 1);

    do_run(2, 128'h1, 128'h1, 128'h2, -1, -1, dk);
    chk("two_done_k", dk, L + 2 + 1);
    chk("two_sig", sig, 128'h3);
    chk("two_wc", word_count, 2);
    chk("two_pass", pass, 0);
`ifdef AES_MON_SNAPSHOT_EN
    chk("two_fmis", first_mismatch, 1);
`endif

    do_run(2, {1'b1, 127'h0}, 128'h0, 128'h87,
           -1, -1, dk);
    chk("poly_sig", sig, 128'h87);
    chk("poly_pass", pass, 1);
`ifdef AES_MON_SNAPSHOT_EN
    chk("poly_last", last_word, 0);
    chk("poly_fmis", first_mismatch, 0);
`endif

    do_run(0, 128'h1, 128'h1, 128'h1, -1, -1, dk);
    chk("zero_done_k", dk, L + 1 + 1);
    chk("zero_wc", word_count, 1);
    chk("zero_sig", sig, 128'h1);

    do_run(4, 128'h1, 128'h1, 128'hf, -1, -1, dk);
    chk("nostall_done_k", dk, L + 4 + 1);
    chk("nostall_sig", sig, 128'hf);
    do_run(4, 128'h1, 128'h1, 128'hf, 4, -1, dk);
    chk("stall_done_k", dk, L + 4 + 1 + 3);
    chk("stall_sig", sig, 128'hf);
    chk("stall_pass", pass, 1);

    do_run(2, 128'h1, 128'h1, 128'h3, -1, 1, dk);
    chk("wstart_done_k", dk, L + 2 + 1);
    chk("wstart_sig", sig, 128'h3);

    do_run(2, 128'h1, 128'h1, 128'h3, -1, L + 1, dk);
    chk("fstart_done_k", dk, L + 2 + 1);
    tick();
    tick();
    tick();
    chk("hold_done", done, 1);
    chk("hold_busy", busy, 0);
    chk("hold_wc", word_count, 2);
    chk("hold_sig", sig, 128'h3);
    chk("hold_pass", pass, 1);

    num_tests = 4;
    out_data  = 128'h1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_pass", pass, 0);
    chk("mrst_sig", sig, 0);
    chk("mrst_wc", word_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_run(1, 128'h5, 128'h5, 128'h5, -1, -1, dk);
    chk("after_done_k", dk, L + 1 + 1);
    chk("after_sig", sig, 128'h5);
    chk("after_pass", pass, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
